lcd_text_scheduler: RTL and testbench

- Owns the 32-character text image shown on the 2x16 character LCD and feeds it byte-by-byte to display_LCD through LCD_display_in/rinc.
- Shares write access to the image between two requesters (status path, message path) with round-robin arbitration.
- Sequences refresh freeze/unfreeze by driving display_LCD's stop_refresh toggle input for exactly one driver frame period.

---
 rtl/lcd_text_scheduler.sv | 150 +++++++++++++++
 tb/tb_lcd_text_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_scheduler.sv
// lcd_text_scheduler
//   Holds the character image for a 2x16 character LCD and streams it one byte
//   at a time to display_LCD. Two requesters share write access to the image
//   through a round-robin arbiter. The block also freezes and unfreezes the
//   driver's refresh by holding stop_refresh high for one driver frame.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   req[1:0]          level write request per requester
//   wr_addr0/1        character address for requester 0/1
//   wr_data0/1        character code for requester 0/1
//   gnt[1:0]          one-hot grant; the granted write commits on this edge
//   rinc              read-increment pulse from display_LCD
//   LCD_display_in    character at the read pointer
//   freeze_req        1 = display frozen, 0 = refreshing
//   stop_refresh      toggle request to display_LCD, high for FRAME_CLKS cycles
//   frozen            freeze state as committed to the driver
//   frame_done        one-cycle pulse after the read pointer wraps
//   ready             clear finished, writes accepted
module lcd_text_scheduler #(
    parameter int          NUM_CHARS  = 32,
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter int          FRAME_CLKS = 134217728,
    localparam int         AW         = $clog2(NUM_CHARS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [AW-1:0] wr_addr0,
    input  logic [7:0]    wr_data0,
    input  logic [AW-1:0] wr_addr1,
    input  logic [7:0]    wr_data1,
    output logic [1:0]    gnt,
    input  logic          rinc,
    output logic [7:0]    LCD_display_in,
    input  logic          freeze_req,
    output logic          stop_refresh,
    output logic          frozen,
    output logic          frame_done,
    output logic          ready
);

    localparam int CW = $clog2(FRAME_CLKS + 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state, next_state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rr_last;
    logic          pend;
    logic [CW-1:0] cnt;
    logic [7:0]    buf_mem [NUM_CHARS];

    logic          wen;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= next_state;
    end

    // Next state, arbitration and write-port selection
    always_comb begin
        next_state = state;
        gnt        = 2'b00;
        wen        = 1'b0;
        wa         = clr_ptr;
        wd         = BLANK_CHAR;
        case (state)
            CLEAR: begin
                wen = 1'b1;
                if (clr_ptr == AW'(NUM_CHARS - 1)) next_state = RUN;
            end
            RUN: begin
                case (req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    // Contention: the side that did not win last time goes first.
                    2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                    default: gnt = 2'b00;
                endcase
                wen = |gnt;
                if (gnt[1]) begin
                    wa = wr_addr1;
                    wd = wr_data1;
                end else begin
                    wa = wr_addr0;
                    wd = wr_data0;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    assign ready = (state == RUN);

    // Old data is visible on a same-address write/read cycle because the
    // read is taken from storage before the edge commits the write.
    assign LCD_display_in = (state == CLEAR) ? BLANK_CHAR : buf_mem[rd_ptr];

    // Image storage; not reset, CLEAR rewrites every location instead.
    always_ff @(posedge clk) begin
        if (!reset && wen) buf_mem[wa] <= wd;
    end

    // Pointers, arbiter history, frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr    <= '0;
            rd_ptr     <= '0;
            rr_last    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (gnt[0])      rr_last <= 1'b0;
            else if (gnt[1]) rr_last <= 1'b1;
            if (rinc) rd_ptr <= rd_ptr + 1'b1;
            frame_done <= rinc && (rd_ptr == AW'(NUM_CHARS - 1));
        end
    end

    // Freeze sequencer: one stop_refresh pulse of FRAME_CLKS cycles spans
    // exactly one driver state wrap, so the driver toggles its stop once.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend         <= 1'b0;
            stop_refresh <= 1'b0;
            frozen       <= 1'b0;
            cnt          <= '0;
        end else if (state == RUN) begin
            if (pend) begin
                if (cnt == CW'(FRAME_CLKS - 1)) begin
                    pend         <= 1'b0;
                    stop_refresh <= 1'b0;
                    frozen       <= ~frozen;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (freeze_req != frozen) begin
                pend         <= 1'b1;
                stop_refresh <= 1'b1;
                cnt          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_scheduler.sv
module tb_lcd_text_scheduler;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [7:0]    wr_data0, wr_data1;
    logic [1:0]    gnt;
    logic          rinc;
    logic [7:0]    LCD_display_in;
    logic          freeze_req;
    logic          stop_refresh, frozen, frame_done, ready;

    int total = 0;
    int bad   = 0;

    lcd_text_scheduler #(
        .NUM_CHARS (32),
        .BLANK_CHAR(8'h20),
        .FRAME_CLKS(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .wr_addr0      (wr_addr0),
        .wr_data0      (wr_data0),
        .wr_addr1      (wr_addr1),
        .wr_data1      (wr_data1),
        .gnt           (gnt),
        .rinc          (rinc),
        .LCD_display_in(LCD_display_in),
        .freeze_req    (freeze_req),
        .stop_refresh  (stop_refresh),
        .frozen        (frozen),
        .frame_done    (frame_done),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_rinc(input int n);
        rinc = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rinc = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        int hi_cnt;

        reset = 1'b1; req = 2'b00; rinc = 1'b0; freeze_req = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_stop", 32'(stop_refresh), 0);
        chk("rst_frozen", 32'(frozen), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_lcd", 32'(LCD_display_in), 32'h20);

        // Clear takes one edge per location
        reset = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        chk("clr_not_ready", 32'(ready), 0);
        tick();
        chk("clr_ready", 32'(ready), 1);

        // Read the whole cleared image; one frame_done after the 32nd rinc
        fd_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            chk("blank_read", 32'(LCD_display_in), 32'h20);
            rinc = 1'b1; tick(); rinc = 1'b0;
            if (frame_done) fd_cnt++;
        end
        chk("fd_last", 32'(frame_done), 1);
        tick();
        chk("fd_one_cycle", 32'(frame_done), 0);
        chk("fd_count", 32'(fd_cnt), 1);
        chk("wrap_ptr0", 32'(LCD_display_in), 32'h20);

        // Contention on addrs 0/1: alternating grants, requester 0 first
        req = 2'b11; wr_addr0 = 5'd0; wr_addr1 = 5'd1;
        for (int i = 0; i < 6; i++) begin
            wr_data0 = 8'h30 + 8'(i);
            wr_data1 = 8'h50 + 8'(i);
            #1;
            chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        req = 2'b00;
        chk("rr_addr0", 32'(LCD_display_in), 32'h34);
        do_rinc(1);
        chk("rr_addr1", 32'(LCD_display_in), 32'h55);

        // Single requester 0 write, addr 5
        req = 2'b01; wr_addr0 = 5'd5; wr_data0 = 8'h41;
        #1;
        chk("single_gnt", 32'(gnt), 32'h1);
        tick();
        req = 2'b00;
        do_rinc(4);
        chk("single_read", 32'(LCD_display_in), 32'h41);

        // Single requester 1 write
        req = 2'b10; wr_addr1 = 5'd6; wr_data1 = 8'h62;
        #1;
        chk("single1_gnt", 32'(gnt), 32'h2);
        tick();
        req = 2'b00;
        do_rinc(1);
        chk("single1_read", 32'(LCD_display_in), 32'h62);

        // Write and read addr 3 in the same cycle: old data, then new
        do_rinc(29);  // rd_ptr 6 -> 3
        req = 2'b01; wr_addr0 = 5'd3; wr_data0 = 8'h7A;
        #1;
        chk("same_addr_old", 32'(LCD_display_in), 32'h20);
        tick();
        req = 2'b00;
        chk("same_addr_new", 32'(LCD_display_in), 32'h7A);

        // Freeze: 16-cycle pulse; freeze_req drop mid-pulse is deferred
        freeze_req = 1'b1;
        tick();
        hi_cnt = 0;
        for (int k = 0; k < 40 && stop_refresh; k++) begin
            hi_cnt++;
            if (k == 3) freeze_req = 1'b0;
            tick();
        end
        chk("frz_len", 32'(hi_cnt), 16);
        chk("frz_frozen", 32'(frozen), 1);
        chk("frz_gap", 32'(stop_refresh), 0);
        tick();
        hi_cnt = 0;
        for (int k = 0; k < 40 && stop_refresh; k++) begin
            hi_cnt++;
            tick();
        end
        chk("unfrz_len", 32'(hi_cnt), 16);
        chk("unfrz_frozen", 32'(frozen), 0);
        tick();
        chk("unfrz_idle", 32'(stop_refresh), 0);

        // Reset during a freeze pulse
        freeze_req = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) tick();
        chk("pre_rst_stop", 32'(stop_refresh), 1);
        reset = 1'b1; req = 2'b01;
        tick();
        chk("mid_rst_stop", 32'(stop_refresh), 0);
        chk("mid_rst_frozen", 32'(frozen), 0);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_ready", 32'(ready), 0);

        // Reset again mid-CLEAR; clear must run its full length again
        reset = 1'b0; freeze_req = 1'b0; req = 2'b00;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        chk("reclr_not_ready", 32'(ready), 0);
        tick();
        chk("reclr_ready", 32'(ready), 1);
        chk("reclr_addr0", 32'(LCD_display_in), 32'h20);
        do_rinc(3);
        chk("reclr_addr3", 32'(LCD_display_in), 32'h20);
        chk("reclr_stop", 32'(stop_refresh), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
